// File: rtl/result_accum_tx.sv
// result_accum_tx
//   Collects DEPTH results from the multiplier pipeline into a running sum.
//   When a batch is complete, the sum is sent MSB-first as NBYTE bytes over a
//   valid/ready byte link. Results that arrive while a send is in progress
//   are dropped and flagged.
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous reset, active low
//   X          16-bit result word
//   X_VALID    X valid this cycle (cannot be stalled)
//   CLR        synchronous abort/clear, active high, highest priority
//   TX_DATA    byte toward the host link
//   TX_VALID   TX_DATA valid
//   TX_READY   host link accepts the byte when TX_VALID & TX_READY
//   SUM        last completed batch sum
//   SUM_VALID  one-cycle pulse when SUM updates
//   COUNT      results accepted in the current batch
//   BUSY       send or done phase in progress
//   OVF        sticky: a result arrived while not collecting
module result_accum_tx #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ACC_W = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [15:0]      X,
  input  logic             X_VALID,
  input  logic             CLR,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic [ACC_W-1:0] SUM,
  output logic             SUM_VALID,
  output logic [7:0]       COUNT,
  output logic             BUSY,
  output logic             OVF
);

  localparam int unsigned NBYTE = ACC_W / 8;

  typedef enum logic [1:0] {StCollect, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   shadow_q, shadow_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [7:0]         count_q, count_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               sum_valid_q, sum_valid_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_sum;
  logic [7:0]         next_byte;

  assign acc_sum = acc_q + {{(ACC_W-16){1'b0}}, X};

  // Byte idx_q+1 counted from the MSB end of the shadow register.
  always_comb begin
    next_byte = 8'h00;
    for (int unsigned b = 0; b < NBYTE; b++) begin
      if (32'(idx_q) + 32'd1 == b) next_byte = shadow_q[ACC_W-1-8*b -: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    shadow_d    = shadow_q;
    sum_d       = sum_q;
    count_d     = count_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    sum_valid_d = 1'b0;
    ovf_d       = ovf_q;

    if (CLR) begin
      // Abort: the in-flight byte is treated as not sent, SUM is kept.
      state_d    = StCollect;
      acc_d      = '0;
      count_d    = '0;
      idx_d      = '0;
      tx_valid_d = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      unique case (state_q)
        StCollect: begin
          if (X_VALID) begin
            if (count_q == 8'(DEPTH - 1)) begin
              shadow_d   = acc_sum;
              acc_d      = '0;
              count_d    = '0;
              idx_d      = '0;
              state_d    = StSend;
              tx_valid_d = 1'b1;
              tx_data_d  = acc_sum[ACC_W-1 -: 8];
            end else begin
              acc_d   = acc_sum;
              count_d = count_q + 8'd1;
            end
          end
        end
        StSend: begin
          if (X_VALID) ovf_d = 1'b1;
          if (tx_valid_q && TX_READY) begin
            if (idx_q < 8'(NBYTE - 1)) begin
              idx_d     = idx_q + 8'd1;
              tx_data_d = next_byte;
            end else begin
              tx_valid_d  = 1'b0;
              sum_d       = shadow_q;
              sum_valid_d = 1'b1;
              state_d     = StDone;
            end
          end
        end
        StDone: begin
          if (X_VALID) ovf_d = 1'b1;
          state_d = StCollect;
        end
        default: state_d = StCollect;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StCollect;
      acc_q       <= '0;
      shadow_q    <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      sum_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      shadow_q    <= shadow_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      sum_valid_q <= sum_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign TX_DATA   = tx_data_q;
  assign TX_VALID  = tx_valid_q;
  assign SUM       = sum_q;
  assign SUM_VALID = sum_valid_q;
  assign COUNT     = count_q;
  assign OVF       = ovf_q;
  assign BUSY      = (state_q != StCollect);

endmodule

// File: tb/tb_result_accum_tx.sv
module tb_result_accum_tx;

  localparam int DEPTH = 16;
  localparam int ACC_W = 24;
  localparam int NBYTE = ACC_W / 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [15:0]      X;
  logic             X_VALID;
  logic             CLR;
  logic [7:0]       TX_DATA;
  logic             TX_VALID;
  logic             TX_READY;
  logic [ACC_W-1:0] SUM;
  logic             SUM_VALID;
  logic [7:0]       COUNT;
  logic             BUSY;
  logic             OVF;

  result_accum_tx #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .X         (X),
    .X_VALID   (X_VALID),
    .CLR       (CLR),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .SUM       (SUM),
    .SUM_VALID (SUM_VALID),
    .COUNT     (COUNT),
    .BUSY      (BUSY),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;
  int sv_cnt   = 0;
  logic [7:0] got[$];

  // Behavioural reference: a batch is a list of accepted words; a finished
  // batch becomes a queue of bytes waiting to be handed to the link.
  int         m_acc;
  int         m_cnt;
  int         m_batch;
  logic [7:0] m_q[$];
  bit         m_done;
  bit         m_ovf;
  bit         m_sv;
  logic [23:0] m_sum;

  typedef struct {
    logic [15:0] x0;
    logic [15:0] dx;
    bit          rnd;
    logic [23:0] exp_sum;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_batch = 0; m_q.delete();
    m_done = 0; m_ovf = 0; m_sv = 0; m_sum = '0;
  endtask

  task automatic model_step();
    if (CLR) begin
      m_acc = 0; m_cnt = 0; m_q.delete(); m_done = 0; m_ovf = 0; m_sv = 0;
    end else begin
      m_sv = 0;
      if (m_done) begin
        m_done = 0;
        if (X_VALID) m_ovf = 1;
      end else if (m_q.size() != 0) begin
        if (X_VALID) m_ovf = 1;
        if (TX_READY) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_sum  = 24'(m_batch);
            m_sv   = 1;
            m_done = 1;
          end
        end
      end else if (X_VALID) begin
        m_acc += int'(X);
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_batch = m_acc;
          for (int b = NBYTE - 1; b >= 0; b--) m_q.push_back(8'((m_batch >> (8 * b)) & 255));
          m_acc = 0;
          m_cnt = 0;
        end
      end
    end
  endtask

  // One clock: update the model from the inputs, step, then compare.
  task automatic cycle();
    if (TX_VALID && TX_READY && !CLR) got.push_back(TX_DATA);
    model_step();
    @(posedge CLK);
    #1;
    if (SUM_VALID) sv_cnt++;
    chk("tx_valid", 32'(TX_VALID), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("tx_data", 32'(TX_DATA), 32'(m_q[0]));
    chk("sum", 32'(SUM), 32'(m_sum));
    chk("sum_valid", 32'(SUM_VALID), 32'(m_sv));
    chk("count", 32'(COUNT), 32'(m_cnt));
    chk("ovf", 32'(OVF), 32'(m_ovf));
    chk("busy", 32'(BUSY), 32'((m_q.size() != 0) || m_done));
  endtask

  task automatic run_batch(input logic [15:0] x0, input logic [15:0] dx, input bit rnd,
                           input logic [23:0] exp_sum);
    int sv0;
    int k;
    int gaps;
    logic [23:0] es;
    got.delete();
    sv0 = sv_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      if (rnd) begin
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          X_VALID = 1'b0; TX_READY = 1'($urandom_range(0, 1)); cycle();
        end
      end
      X_VALID  = 1'b1;
      X        = x0 + 16'(i) * dx;
      TX_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
    end
    X_VALID = 1'b0;
    chk("tx_valid_after_last_word", 32'(TX_VALID), 32'd1);
    k = 0;
    while ((sv_cnt == sv0 || BUSY) && k < 200) begin
      TX_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      k++;
    end
    chk("batch_timeout", 32'(k < 200), 32'd1);
    if (!rnd) chk("batch_cycles", 32'(k), 32'(NBYTE + 1));
    es = exp_sum;
    chk("byte_count", 32'(got.size()), 32'(NBYTE));
    for (int b = 0; b < NBYTE; b++) begin
      if (b < got.size()) chk("tx_byte", 32'(got[b]), 32'(es[8*(NBYTE-1-b) +: 8]));
    end
    chk("batch_sum", 32'(SUM), 32'(exp_sum));
    chk("sum_valid_pulses", 32'(sv_cnt - sv0), 32'd1);
    chk("count_after_batch", 32'(COUNT), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   k;
    int   sv0;

    vecs[0] = '{x0: 16'hFE01, dx: 16'h0000, rnd: 1'b0, exp_sum: 24'h0FE010};
    vecs[1] = '{x0: 16'h0001, dx: 16'h0001, rnd: 1'b1, exp_sum: 24'h000088};
    vecs[2] = '{x0: 16'hFFFF, dx: 16'h0000, rnd: 1'b1, exp_sum: 24'h0FFFF0};
    vecs[3] = '{x0: 16'h0000, dx: 16'h0000, rnd: 1'b0, exp_sum: 24'h000000};
    vecs[4] = '{x0: 16'h0100, dx: 16'h0100, rnd: 1'b0, exp_sum: 24'h008800};

    RST = 1'b0; X = '0; X_VALID = 1'b0; CLR = 1'b0; TX_READY = 1'b0;
    model_reset();
    #12;
    chk("rst_tx_data", 32'(TX_DATA), 32'd0);
    chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
    chk("rst_sum", 32'(SUM), 32'd0);
    chk("rst_sum_valid", 32'(SUM_VALID), 32'd0);
    chk("rst_count", 32'(COUNT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    RST = 1'b1;

    foreach (vecs[i]) run_batch(vecs[i].x0, vecs[i].dx, vecs[i].rnd, vecs[i].exp_sum);
    chk("ovf_after_table", 32'(OVF), 32'd0);

    // Words arriving during a send are dropped and flagged.
    TX_READY = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin X_VALID = 1'b1; X = 16'd5; cycle(); end
    X_VALID = 1'b0; cycle();
    X_VALID = 1'b1; X = 16'd7; cycle(); cycle();
    X_VALID = 1'b0;
    chk("ovf_set", 32'(OVF), 32'd1);
    chk("tx_held", 32'(TX_DATA), 32'h00);
    TX_READY = 1'b1;
    k = 0;
    while (BUSY && k < 20) begin cycle(); k++; end
    chk("ovf_drain_sum", 32'(SUM), 32'h50);
    run_batch(16'd2, 16'd0, 1'b0, 24'd32);
    chk("ovf_sticky", 32'(OVF), 32'd1);

    // CLR together with X_VALID mid-batch: partial batch and that word discarded.
    for (int i = 0; i < 7; i++) begin X_VALID = 1'b1; X = 16'd3; cycle(); end
    CLR = 1'b1; cycle();
    CLR = 1'b0; X_VALID = 1'b0;
    chk("clr_count", 32'(COUNT), 32'd0);
    chk("clr_ovf", 32'(OVF), 32'd0);
    run_batch(16'd3, 16'd0, 1'b0, 24'd48);

    // CLR on the second byte's handshake.
    TX_READY = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin X_VALID = 1'b1; X = 16'd4; cycle(); end
    X_VALID = 1'b0; TX_READY = 1'b1; cycle();
    sv0 = sv_cnt;
    CLR = 1'b1; cycle();
    CLR = 1'b0;
    chk("clr_send_tx_valid", 32'(TX_VALID), 32'd0);
    chk("clr_send_busy", 32'(BUSY), 32'd0);
    chk("clr_send_sum", 32'(SUM), 32'd48);
    for (int i = 0; i < 4; i++) cycle();
    chk("clr_send_no_sum_valid", 32'(sv_cnt - sv0), 32'd0);

    // Asynchronous reset between edges while sending.
    TX_READY = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin X_VALID = 1'b1; X = 16'd9; cycle(); end
    X_VALID = 1'b0;
    chk("pre_async_busy", 32'(BUSY), 32'd1);
    #3 RST = 1'b0;
    #1;
    chk("async_tx_valid", 32'(TX_VALID), 32'd0);
    chk("async_busy", 32'(BUSY), 32'd0);
    chk("async_count", 32'(COUNT), 32'd0);
    chk("async_sum", 32'(SUM), 32'd0);
    model_reset();
    #1 RST = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      X_VALID  = ($urandom_range(0, 9) < 6);
      X        = 16'($urandom);
      TX_READY = 1'($urandom_range(0, 1));
      CLR      = ($urandom_range(0, 63) == 0);
      cycle();
    end
    CLR = 1'b0; X_VALID = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
